ppi_frame_tx: RTL and testbench
===============================

# ppi_frame_tx

Transmitter for the PPI parameter frame used by the synchroniser board. It serialises eight 32-bit timing words (TNO, TNC, TOBM, TNI, TKI, TNP, TKP, Rzv) into the 35-byte frame consumed by the PPI receiver: header 0xAA, version 0x01, 32 payload bytes MSB-first, then an 8-bit additive checksum. It generates the PPI byte clock, the frame-sync strobe and the byte bus from one system clock. It sits on the stand/master side, driving the same PPI link the receiver listens on.

## Interface
- DIV_HALF, 2, system-clock cycles per half period of ppi_clk (≥1); ppi_clk period = 2·DIV_HALF clk.
- GAP_CYC, 4, ppi_clk periods of idle bus after the checksum byte before done/next frame (≥4).
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  frame request; pulse; ignored while busy=1.
- crc_inv  in  1  sampled with start; 1 = send inverted checksum (fault injection).
- TNO, TNC, TOBM, TNI, TKI, TNP, TKP, Rzv  in  32 each  payload words; snapshotted when a frame is accepted.
- ppi_clk  out  1  free-running PPI byte clock.
- ppi_data  out  8  byte bus; changes only on ppi_clk rising.
- ppi_fs1  out  1  frame-sync strobe; changes only on ppi_clk falling.
- busy  out  1  frame accepted and not finished.
- done  out  1  one-clk pulse at end of gap.

## Operation
- Divider: counter hc 0..DIV_HALF-1; ppi_clk toggles when hc wraps. RISE/FALL events are the clk cycles in which the registered ppi_clk goes 0→1 / 1→0. All outputs are registered and update on the same clk edge as ppi_clk.
- start while busy=0 sets pending (holds until consumed) and asserts busy in the next cycle. start while busy=1 is dropped; pending is never double-set.
- FSM states and transitions:
  - IDLE: on a FALL event with pending set: snapshot the 8 words and crc_inv, clear pending, ppi_fs1←1, go to SYNC.
  - SYNC: on the next FALL: ppi_fs1←0, go to LEAD.
  - LEAD: ignore the first RISE; on the second RISE drive byte 0, go to DATA. This places byte 0 on the bus at the second falling edge after the receiver first samples fs high.
  - DATA: on each RISE drive byte n+1. After byte 34 has been on the bus for one period, the next RISE drives 0x00 and goes to GAP.
  - GAP: count GAP_CYC RISE events, then done←1 for one clk, busy←0, go to IDLE.
- Byte map: 0=0xAA, 1=0x01, 2..5=TNO[31:24..7:0], 6..9=TNC, 10..13=TOBM, 14..17=TNI, 18..21=TKI, 22..25=TNP, 26..29=TKP, 30..33=Rzv, 34=checksum.
- Checksum: 8-bit sum of bytes 0..33 modulo 256, carries discarded, accumulated as bytes are driven. Byte 34 = sum, or ~sum when the latched crc_inv=1.
- Input words changing after acceptance have no effect on the frame in flight.
- Idle bus: ppi_data=0x00, ppi_fs1=0.

## Timing
- Reset (rst=1 at a posedge) forces, from the next cycle: ppi_clk=0, hc=0, ppi_data=0x00, ppi_fs1=0, busy=0, done=0, pending=0, checksum=0, FSM=IDLE. This applies mid-frame too: the frame is abandoned and no done pulse is issued.
- start→busy: 1 clk. start→ppi_fs1 rise: first FALL event at least 1 clk after start.
- ppi_fs1 high for exactly one ppi_clk period.
- Byte n is first driven at RISE R(2+n), counting R0 as the first rise while fs is high. Each byte is held one full ppi_clk period.
- Frame length from fs rise to done: 1 + 1 + 35 + GAP_CYC ppi_clk periods, ±1 half-period.
- start coinciding with rst: rst wins, start is lost. start in the same cycle done pulses: busy is still 1, so start is dropped.

## Test plan
- Reset: hold rst 3 clk mid-DATA → all outputs at reset values the next cycle; no done; ppi_clk stays 0 while rst=1 and then resumes.
- Single frame: TNO=0x11223344, other words 0, crc_inv=0 → bytes AA 01 11 22 33 44 followed by 28×00, then checksum 0x55. ppi_fs1 is high for one period and byte 0 appears at R2.
- All words 0xFFFFFFFF → 32 payload bytes of 0xFF, checksum 0x8B. A reference receiver model reports OK and reproduces all eight words.
- Fault injection: same as above with crc_inv=1 → checksum 0x74. The receiver model flags a CRC failure and does not update the words.
- Start while busy at byte 10 → ignored, only one frame is sent. start on the cycle after done → second frame, with at least GAP_CYC idle periods between checksum and the next fs rise.
- DIV_HALF=1 and DIV_HALF=5 → ppi_clk periods of 2 and 10 clk. Data only changes on RISE and fs only changes on FALL, checked by assertion.

Source files
------------

// File: rtl/ppi_frame_tx.sv
// ppi_frame_tx: serialises eight 32-bit timing words into the 35-byte PPI frame
// (0xAA, 0x01, 32 payload bytes MSB-first, additive checksum). It generates the
// PPI byte clock, the frame-sync strobe and the byte bus from one system clock.
// Bytes change on the ppi_clk rising edge and fs changes on the falling edge, so
// the receiver always samples stable values.
module ppi_frame_tx #(
    parameter int DIV_HALF = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        crc_inv,
    input  logic [31:0] TNO,
    input  logic [31:0] TNC,
    input  logic [31:0] TOBM,
    input  logic [31:0] TNI,
    input  logic [31:0] TKI,
    input  logic [31:0] TNP,
    input  logic [31:0] TKP,
    input  logic [31:0] Rzv,
    output logic        ppi_clk,
    output logic [7:0]  ppi_data,
    output logic        ppi_fs1,
    output logic        busy,
    output logic        done
);

    localparam int HC_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int GC_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(DIV_HALF - 1);
    localparam logic [GC_W-1:0] GC_LAST  = GC_W'(GAP_CYC - 1);
    localparam logic [5:0]      IDX_CSUM = 6'd34;
    localparam logic [5:0]      IDX_END  = 6'd35;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEAD = 3'd2,
        S_DATA = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic            pclk_q, pclk_d;
    logic [7:0]      data_q, data_d;
    logic            fs_q, fs_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pend_q, pend_d;
    logic            inv_pend_q, inv_pend_d;
    logic            inv_q, inv_d;
    logic [7:0]      sum_q, sum_d;
    logic [255:0]    payload_q, payload_d;
    logic [5:0]      idx_q, idx_d;
    logic            lead_q, lead_d;
    logic [GC_W-1:0] gap_q, gap_d;

    logic            wrap_s, rise_s, fall_s;
    logic [7:0]      cur_byte_s;

    // Byte n of the frame; the payload byte is always the top of the shift register.
    function automatic logic [7:0] frame_byte(input logic [5:0] idx,
                                              input logic [7:0] payload_top,
                                              input logic [7:0] sum,
                                              input logic       inv);
        case (idx)
            6'd0:     frame_byte = 8'hAA;
            6'd1:     frame_byte = 8'h01;
            IDX_CSUM: frame_byte = inv ? ~sum : sum;
            default:  frame_byte = payload_top;
        endcase
    endfunction

    assign wrap_s     = (hc_q == HC_LAST);
    assign rise_s     = wrap_s && !pclk_q;
    assign fall_s     = wrap_s && pclk_q;
    assign cur_byte_s = frame_byte(idx_q, payload_q[255:248], sum_q, inv_q);

    // Next-state logic: divider, request handshake and frame sequencer.
    always_comb begin
        state_d    = state_q;
        hc_d       = hc_q;
        pclk_d     = pclk_q;
        data_d     = data_q;
        fs_d       = fs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        inv_pend_d = inv_pend_q;
        inv_d      = inv_q;
        sum_d      = sum_q;
        payload_d  = payload_q;
        idx_d      = idx_q;
        lead_d     = lead_q;
        gap_d      = gap_q;

        if (wrap_s) begin
            hc_d   = {HC_W{1'b0}};
            pclk_d = ~pclk_q;
        end else begin
            hc_d   = hc_q + HC_W'(1);
            pclk_d = pclk_q;
        end

        // busy stays high through the done cycle so a start there is dropped.
        if (done_q) begin
            busy_d = 1'b0;
        end else if (start && !busy_q) begin
            pend_d     = 1'b1;
            busy_d     = 1'b1;
            inv_pend_d = crc_inv;
        end else begin
            busy_d = busy_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall_s && pend_q) begin
                    payload_d = {TNO, TNC, TOBM, TNI, TKI, TNP, TKP, Rzv};
                    inv_d     = inv_pend_q;
                    pend_d    = 1'b0;
                    fs_d      = 1'b1;
                    sum_d     = 8'h00;
                    idx_d     = 6'd0;
                    lead_d    = 1'b0;
                    state_d   = S_SYNC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SYNC: begin
                if (fall_s) begin
                    fs_d    = 1'b0;
                    state_d = S_LEAD;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_LEAD: begin
                // The first rise in LEAD is skipped so byte 0 lands at R2.
                if (rise_s && lead_q) begin
                    data_d  = cur_byte_s;
                    sum_d   = sum_q + cur_byte_s;
                    idx_d   = 6'd1;
                    state_d = S_DATA;
                end else if (rise_s) begin
                    lead_d = 1'b1;
                end else begin
                    lead_d = lead_q;
                end
            end
            S_DATA: begin
                if (rise_s && (idx_q == IDX_END)) begin
                    data_d  = 8'h00;
                    gap_d   = {GC_W{1'b0}};
                    state_d = S_GAP;
                end else if (rise_s) begin
                    data_d = cur_byte_s;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q < IDX_CSUM) begin
                        sum_d = sum_q + cur_byte_s;
                    end else begin
                        sum_d = sum_q;
                    end
                    if ((idx_q >= 6'd2) && (idx_q < IDX_CSUM)) begin
                        payload_d = {payload_q[247:0], 8'h00};
                    end else begin
                        payload_d = payload_q;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_GAP: begin
                if (rise_s && (gap_q == GC_LAST)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rise_s) begin
                    gap_d = gap_q + GC_W'(1);
                end else begin
                    gap_d = gap_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                data_d  = 8'h00;
                fs_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hc_q       <= {HC_W{1'b0}};
            pclk_q     <= 1'b0;
            data_q     <= 8'h00;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            inv_pend_q <= 1'b0;
            inv_q      <= 1'b0;
            sum_q      <= 8'h00;
            payload_q  <= 256'd0;
            idx_q      <= 6'd0;
            lead_q     <= 1'b0;
            gap_q      <= {GC_W{1'b0}};
        end else begin
            state_q    <= state_d;
            hc_q       <= hc_d;
            pclk_q     <= pclk_d;
            data_q     <= data_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            inv_pend_q <= inv_pend_d;
            inv_q      <= inv_d;
            sum_q      <= sum_d;
            payload_q  <= payload_d;
            idx_q      <= idx_d;
            lead_q     <= lead_d;
            gap_q      <= gap_d;
        end
    end

    assign ppi_clk  = pclk_q;
    assign ppi_data = data_q;
    assign ppi_fs1  = fs_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ppi_frame_tx.sv
// tb_ppi_frame_tx: three transmitters (DIV_HALF 2, 1, 5) each run the same
// sequence. Stimulus pushes the expected frame bytes into a scoreboard; a
// negedge monitor pops a frame at each fs rise and checks bytes, timing and
// a reference receiver's verdict.
module tb_ppi_frame_tx;

    localparam int GAP = 4;
    localparam int LIM = 3000;

    logic clk = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   fin [3];

    always #5 clk = ~clk;

    task automatic check(input int inst, input string name,
                         input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0h, expected %0h", inst, name, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int GI = gi;
        localparam int DH = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);

        logic        rst = 1'b1;
        logic        start = 1'b0;
        logic        crc_inv = 1'b0;
        logic [31:0] w [8];
        logic        ppi_clk, ppi_fs1, busy, done;
        logic [7:0]  ppi_data;

        logic [7:0]  exp_b [$];
        bit          exp_inv [$];
        logic [31:0] exp_w [$];

        logic [7:0]  cur [35];
        logic [7:0]  cap [35];
        logic [31:0] cur_w [8];
        logic [31:0] rx_w [8];
        bit          cur_inv;
        bit          active = 1'b0;
        bit          skip = 1'b1;
        int          ridx = 0;
        int          fs_cyc = 0;
        int          cyc = 0;
        int          end_cyc = 0;
        bit          have_end = 1'b0;
        int          tog_cnt = 0;
        bit          tog_valid = 1'b0;
        logic        p_clk, p_fs, p_done;
        logic [7:0]  p_data;

        ppi_frame_tx #(.DIV_HALF(DH), .GAP_CYC(GAP)) dut (
            .clk(clk), .rst(rst), .start(start), .crc_inv(crc_inv),
            .TNO(w[0]), .TNC(w[1]), .TOBM(w[2]), .TNI(w[3]),
            .TKI(w[4]), .TNP(w[5]), .TKP(w[6]), .Rzv(w[7]),
            .ppi_clk(ppi_clk), .ppi_data(ppi_data), .ppi_fs1(ppi_fs1),
            .busy(busy), .done(done)
        );

        // Reference frame: header, words MSB-first, sum of bytes 0..33 mod 256.
        task automatic push_exp(input bit inv);
            int s;
            logic [7:0] b;
            s = 32'hAA + 32'h01;
            exp_b.push_back(8'hAA);
            exp_b.push_back(8'h01);
            for (int k = 0; k < 8; k++) begin
                for (int j = 3; j >= 0; j--) begin
                    b = w[k][8*j +: 8];
                    exp_b.push_back(b);
                    s = s + int'(b);
                end
            end
            b = 8'(s % 256);
            if (inv) b = ~b;
            exp_b.push_back(b);
            exp_inv.push_back(inv);
            for (int k = 0; k < 8; k++) exp_w.push_back(w[k]);
        endtask

        task automatic rand_words();
            for (int k = 0; k < 8; k++) w[k] = $urandom();
        endtask

        task automatic set_words(input logic [31:0] first, input logic [31:0] rest);
            w[0] = first;
            for (int k = 1; k < 8; k++) w[k] = rest;
        endtask

        function automatic bit cond(input int which, input int n);
            case (which)
                0:       return !busy;
                1:       return ppi_fs1;
                2:       return done;
                3:       return active && (ridx >= n);
                default: return 1'b0;
            endcase
        endfunction

        task automatic wait_for(input int which, input int n, input string name);
            int t = 0;
            while (!cond(which, n) && t < LIM) begin
                @(posedge clk); #1;
                t++;
            end
            check(GI, name, cond(which, n), 1);
        endtask

        task automatic check_reset_vals();
            check(GI, "rst_ppi_clk", ppi_clk, 0);
            check(GI, "rst_data", ppi_data, 0);
            check(GI, "rst_fs", ppi_fs1, 0);
            check(GI, "rst_busy", busy, 0);
            check(GI, "rst_done", done, 0);
        endtask

        // Issue a start, check busy, then change the words once the frame is latched.
        task automatic send(input bit inv);
            wait_for(0, 0, "wait_idle");
            crc_inv = inv;
            start = 1'b1;
            push_exp(inv);
            @(posedge clk); #1;
            start = 1'b0;
            check(GI, "start_to_busy", busy, 1);
            wait_for(1, 0, "wait_fs");
            rand_words();
        endtask

        // Stimulus sequence for this configuration.
        initial begin
            set_words(32'h0, 32'h0);
            repeat (3) begin @(posedge clk); #1; end
            check_reset_vals();
            rst = 1'b0;

            set_words(32'h11223344, 32'h0);
            send(1'b0);
            wait_for(2, 0, "done_a");
            set_words(32'hFFFFFFFF, 32'hFFFFFFFF);
            send(1'b0);
            wait_for(2, 0, "done_b");
            set_words(32'hFFFFFFFF, 32'hFFFFFFFF);
            send(1'b1);
            wait_for(2, 0, "done_c");

            // start while busy is dropped; start in the done cycle is dropped,
            // start in the cycle after done is taken.
            rand_words();
            send(1'($urandom_range(0, 1)));
            wait_for(3, 12, "reach_byte10");
            check(GI, "busy_mid", busy, 1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check(GI, "busy_after_drop", busy, 1);
            wait_for(2, 0, "done_d");
            crc_inv = 1'($urandom_range(0, 1));
            start = 1'b1;
            @(posedge clk); #1;
            check(GI, "busy_after_done", busy, 0);
            push_exp(crc_inv);
            @(posedge clk); #1;
            start = 1'b0;
            check(GI, "busy_second", busy, 1);
            wait_for(1, 0, "wait_fs_e");
            rand_words();
            wait_for(2, 0, "done_e");

            // Reset in the middle of the payload abandons the frame.
            send(1'b0);
            wait_for(3, 20, "reach_byte18");
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check(GI, "rst_hold_clk", ppi_clk, 0);
            end
            exp_b.delete();
            exp_inv.delete();
            exp_w.delete();
            check_reset_vals();
            rst = 1'b0;
            begin
                bit saw = 1'b0;
                repeat (2 * DH + 2) begin
                    @(posedge clk); #1;
                    if (ppi_clk) saw = 1'b1;
                end
                check(GI, "clk_resume", saw, 1);
            end
            repeat (20 * DH) begin @(posedge clk); #1; end

            for (int f = 0; f < 3; f++) begin
                rand_words();
                send(1'($urandom_range(0, 1)));
                wait_for(2, 0, "done_rand");
            end
            repeat (10 * DH) begin @(posedge clk); #1; end
            check(GI, "sb_empty", exp_b.size(), 0);
            check(GI, "no_open_frame", active, 0);
            fin[GI] = 1'b1;
        end

        // Monitor: clock/edge discipline, frame bytes, fs width, gap and done timing.
        always @(negedge clk) begin : mon
            bit rise, fall, ok;
            int s;
            cyc++;
            if (rst || skip) begin
                skip = rst;
                active = 1'b0;
                tog_valid = 1'b0;
                tog_cnt = 0;
                have_end = 1'b0;
            end else begin
                rise = !p_clk && ppi_clk;
                fall = p_clk && !ppi_clk;
                tog_cnt++;
                if (ppi_clk != p_clk) begin
                    if (tog_valid) check(GI, "half_period", tog_cnt, DH);
                    tog_cnt = 0;
                    tog_valid = 1'b1;
                end
                if (ppi_data != p_data) check(GI, "data_on_rise", rise, 1);
                if (ppi_fs1 != p_fs) check(GI, "fs_on_fall", fall, 1);
                if (active && ppi_fs1) fs_cyc++;
                if (ppi_fs1 && !p_fs) begin
                    check(GI, "frame_expected", (exp_b.size() >= 35) && !active, 1);
                    if (have_end) check(GI, "gap_len", (cyc - end_cyc) >= GAP * 2 * DH, 1);
                    if (exp_b.size() >= 35) begin
                        for (int i = 0; i < 35; i++) cur[i] = exp_b.pop_front();
                        cur_inv = exp_inv.pop_front();
                        for (int k = 0; k < 8; k++) cur_w[k] = exp_w.pop_front();
                        active = 1'b1;
                        ridx = -1;
                        fs_cyc = 1;
                    end
                end
                if (!ppi_fs1 && p_fs && active) check(GI, "fs_width", fs_cyc, 2 * DH);
                if (rise && active) begin
                    ridx++;
                    if (ridx == 0) check(GI, "fs_at_R0", ppi_fs1, 1);
                    if (ridx >= 2 && ridx <= 36) begin
                        cap[ridx-2] = ppi_data;
                        check(GI, "frame_byte", ppi_data, cur[ridx-2]);
                    end
                    if (ridx == 36) begin
                        // Reference receiver: header, version and checksum must agree.
                        s = 0;
                        for (int i = 0; i < 34; i++) s = s + int'(cap[i]);
                        ok = (cap[0] == 8'hAA) && (cap[1] == 8'h01) && (8'(s % 256) == cap[34]);
                        check(GI, "rx_ok", ok, !cur_inv);
                        if (ok) begin
                            for (int k = 0; k < 8; k++) begin
                                rx_w[k] = {cap[2+4*k], cap[3+4*k], cap[4+4*k], cap[5+4*k]};
                                check(GI, "rx_word", rx_w[k], cur_w[k]);
                            end
                        end
                    end
                    if (ridx == 37) begin
                        check(GI, "gap_data", ppi_data, 0);
                        end_cyc = cyc;
                        have_end = 1'b1;
                    end
                end
                if (done) begin
                    check(GI, "done_expected", active && (ridx == 37 + GAP), 1);
                    check(GI, "done_pulse", p_done, 0);
                    check(GI, "busy_at_done", busy, 1);
                    active = 1'b0;
                end
            end
            p_clk  = ppi_clk;
            p_fs   = ppi_fs1;
            p_done = done;
            p_data = ppi_data;
        end
    end

    // Wait for every configuration, then report.
    initial begin
        int t = 0;
        while (!(fin[0] && fin[1] && fin[2]) && t < 80000) begin
            @(posedge clk);
            t++;
        end
        if (!(fin[0] && fin[1] && fin[2])) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d%0d%0d finished, expected 111", fin[0], fin[1], fin[2]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
